// File: rtl/snr_gate_if.sv
// SNR gate handshake bundle: upstream SNR sample stream, calibration
// control, and the downstream gate-state beat stream.
interface snr_gate_if #(
  parameter int SNR_WIDTH = 16
);

  logic [SNR_WIDTH-1:0] snr_db;
  logic                 snr_valid;
  logic                 snr_ready;
  logic                 recalibrate;
  logic                 quiet_period;
  logic                 voice_active;
  logic                 onset;
  logic                 gate_valid;
  logic                 gate_ready;

  // Environment side: produces samples, consumes gate beats.
  modport master (
    output snr_db, snr_valid, recalibrate, gate_ready,
    input  snr_ready, quiet_period, voice_active, onset, gate_valid
  );

  // Gate side: consumes samples, produces gate beats.
  modport slave (
    input  snr_db, snr_valid, recalibrate, gate_ready,
    output snr_ready, quiet_period, voice_active, onset, gate_valid
  );

endinterface

// File: rtl/snr_gate.sv
// SNR voice-activity gate: calibrates on the first CAL_SAMPLES accepted
// samples, then opens after ATTACK_COUNT consecutive samples at or above
// ON_DB and closes after HANG_COUNT consecutive samples below OFF_DB.
// Every accepted sample yields one output beat one cycle later.
module snr_gate #(
  parameter int SNR_WIDTH    = 16,
  parameter int CAL_SAMPLES  = 4096,
  parameter int ON_DB        = 12,
  parameter int OFF_DB       = 6,
  parameter int ATTACK_COUNT = 4,
  parameter int HANG_COUNT   = 2048
) (
  input logic       clk,
  input logic       rst_n,
  snr_gate_if.slave gate_if
);

  localparam int CAL_W  = $clog2(CAL_SAMPLES + 1);
  localparam int ATK_W  = $clog2(ATTACK_COUNT + 1);
  localparam int HANG_W = $clog2(HANG_COUNT + 1);

  localparam logic signed [SNR_WIDTH-1:0] ON_TH  = SNR_WIDTH'(ON_DB);
  localparam logic signed [SNR_WIDTH-1:0] OFF_TH = SNR_WIDTH'(OFF_DB);

  typedef enum logic [2:0] {
    CALIB,
    IDLE,
    ATTACK,
    ACTIVE,
    HANG
  } state_t;

  state_t              state_q,     state_d;
  logic [CAL_W-1:0]    calCount_q,  calCount_d;
  logic [ATK_W-1:0]    atkCount_q,  atkCount_d;
  logic [HANG_W-1:0]   hangCount_q, hangCount_d;

  logic                gateValid_q;
  logic                voiceActive_q;
  logic                onset_q;
  logic                quietPeriod_q;

  logic signed [SNR_WIDTH-1:0] sample;
  logic                        aboveOn;
  logic                        belowOff;
  logic                        snrReady;
  logic                        accept;
  logic                        advance;
  logic                        voiceNext;

  assign sample   = $signed(gate_if.snr_db);
  assign aboveOn  = (sample >= ON_TH);
  assign belowOff = (sample < OFF_TH);

  // A new sample may enter whenever the output slot is empty or draining.
  assign snrReady = !gateValid_q || gate_if.gate_ready;
  assign accept   = gate_if.snr_valid && snrReady;
  // Recalibrate swallows any sample accepted alongside it.
  assign advance  = accept && !gate_if.recalibrate;

  assign voiceNext = (state_d == ACTIVE) || (state_d == HANG);

  // Next-state and counter logic; only recalibrate or an accepted sample moves it.
  always_comb begin
    state_d     = state_q;
    calCount_d  = calCount_q;
    atkCount_d  = atkCount_q;
    hangCount_d = hangCount_q;

    if (gate_if.recalibrate) begin
      state_d     = CALIB;
      calCount_d  = '0;
      atkCount_d  = '0;
      hangCount_d = '0;
    end else if (accept) begin
      case (state_q)
        CALIB: begin
          if (calCount_q == CAL_W'(CAL_SAMPLES - 1)) begin
            state_d    = IDLE;
            calCount_d = '0;
          end else begin
            calCount_d = calCount_q + CAL_W'(1);
          end
        end
        IDLE: begin
          if (aboveOn) begin
            if (ATTACK_COUNT == 1) begin
              state_d = ACTIVE;
            end else begin
              state_d    = ATTACK;
              atkCount_d = ATK_W'(1);
            end
          end
        end
        ATTACK: begin
          if (aboveOn) begin
            if (atkCount_q == ATK_W'(ATTACK_COUNT - 1)) begin
              state_d    = ACTIVE;
              atkCount_d = '0;
            end else begin
              atkCount_d = atkCount_q + ATK_W'(1);
            end
          end else begin
            state_d    = IDLE;
            atkCount_d = '0;
          end
        end
        ACTIVE: begin
          if (belowOff) begin
            if (HANG_COUNT == 1) begin
              state_d = IDLE;
            end else begin
              state_d     = HANG;
              hangCount_d = HANG_W'(1);
            end
          end
        end
        HANG: begin
          if (!belowOff) begin
            state_d     = ACTIVE;
            hangCount_d = '0;
          end else if (hangCount_q == HANG_W'(HANG_COUNT - 1)) begin
            state_d     = IDLE;
            hangCount_d = '0;
          end else begin
            hangCount_d = hangCount_q + HANG_W'(1);
          end
        end
        default: begin
          state_d     = CALIB;
          calCount_d  = '0;
          atkCount_d  = '0;
          hangCount_d = '0;
        end
      endcase
    end
  end

  // State and counter registers; quiet_period is a registered decode of CALIB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CALIB;
      calCount_q    <= '0;
      atkCount_q    <= '0;
      hangCount_q   <= '0;
      quietPeriod_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      calCount_q    <= calCount_d;
      atkCount_q    <= atkCount_d;
      hangCount_q   <= hangCount_d;
      quietPeriod_q <= (state_d == CALIB);
    end
  end

  // Output beat register: load on an accepted sample, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gateValid_q   <= 1'b0;
      voiceActive_q <= 1'b0;
      onset_q       <= 1'b0;
    end else if (advance) begin
      gateValid_q   <= 1'b1;
      voiceActive_q <= voiceNext;
      onset_q       <= voiceNext && !voiceActive_q;
    end else if (gate_if.gate_ready) begin
      gateValid_q   <= 1'b0;
    end
  end

  assign gate_if.snr_ready    = snrReady;
  assign gate_if.gate_valid   = gateValid_q;
  assign gate_if.voice_active = voiceActive_q;
  assign gate_if.onset        = onset_q;
  assign gate_if.quiet_period = quietPeriod_q;

endmodule

// File: tb/tb_snr_gate.sv
// Scoreboard bench for snr_gate: the driver pushes the expected beat of
// every accepted sample, a separate monitor pops it when the beat leaves.
module tb_snr_gate;

  localparam int W    = 16;
  localparam int CAL  = 8;
  localparam int ON   = 12;
  localparam int OFF  = 6;
  localparam int ATK  = 3;
  localparam int HANG = 4;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  snr_gate_if #(.SNR_WIDTH(W)) bus ();

  snr_gate #(
    .SNR_WIDTH   (W),
    .CAL_SAMPLES (CAL),
    .ON_DB       (ON),
    .OFF_DB      (OFF),
    .ATTACK_COUNT(ATK),
    .HANG_COUNT  (HANG)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .gate_if(bus)
  );

  typedef struct {
    bit voice;
    bit onset;
  } beat_t;

  beat_t expQ[$];

  int passCount  = 0;
  int checkCount = 0;

  // Reference model: gate opens on a long enough run of loud samples and
  // closes on a long enough run of quiet ones, after a calibration period.
  int calLeft;
  bit isOpen;
  int aboveRun;
  int belowRun;
  bit lastVoice;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic modelReset();
    calLeft   = CAL;
    isOpen    = 1'b0;
    aboveRun  = 0;
    belowRun  = 0;
    lastVoice = 1'b0;
  endtask

  task automatic modelRecal();
    calLeft  = CAL;
    isOpen   = 1'b0;
    aboveRun = 0;
    belowRun = 0;
  endtask

  task automatic modelSample(input int s);
    beat_t b;
    if (calLeft > 0) begin
      calLeft--;
    end else if (!isOpen) begin
      if (s >= ON) aboveRun++;
      else aboveRun = 0;
      if (aboveRun >= ATK) begin
        isOpen   = 1'b1;
        aboveRun = 0;
      end
    end else begin
      if (s < OFF) belowRun++;
      else belowRun = 0;
      if (belowRun >= HANG) begin
        isOpen   = 1'b0;
        belowRun = 0;
      end
    end
    b.voice   = isOpen;
    b.onset   = isOpen && !lastVoice;
    lastVoice = isOpen;
    expQ.push_back(b);
  endtask

  // Offer one sample (or a recalibrate pulse), retrying until accepted.
  task automatic applyStimulus(input int s, input bit recal, input bit gready,
                               output bit firstTry);
    int tries = 0;
    bit done  = 1'b0;
    firstTry  = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      bus.snr_valid   = 1'b1;
      bus.snr_db      = W'(s);
      bus.recalibrate = recal;
      bus.gate_ready  = (tries == 0) ? gready : 1'b1;
      @(negedge clk);
      checkOutput("quiet_period", int'(bus.quiet_period), int'(calLeft > 0));
      if (recal) begin
        modelRecal();
        done = 1'b1;
      end else if (bus.snr_ready) begin
        modelSample(s);
        firstTry = (tries == 0);
        done     = 1'b1;
      end else begin
        tries++;
        if (tries > 20) begin
          checkOutput("snr_ready_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.snr_valid   = 1'b0;
    bus.recalibrate = 1'b0;
  endtask

  function automatic int randomSample();
    int pick;
    pick = int'($urandom_range(0, 19));
    case (pick)
      0:       return -32768;
      1:       return 32767;
      2:       return ON;
      3:       return ON - 1;
      4:       return OFF;
      5:       return OFF - 1;
      default: return int'($urandom_range(0, 30)) - 8;
    endcase
  endfunction

  // Monitor: every beat taken downstream must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.gate_valid === 1'b1 && bus.gate_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          checkOutput("voice_active", int'(bus.voice_active), int'(e.voice));
          checkOutput("onset", int'(bus.onset), int'(e.onset));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    bit ft;
    int seqA[6] = '{20, 20, 5, 20, 20, 20};
    int seqB[7] = '{3, 3, 8, 3, 3, 3, 3};

    bus.snr_valid   = 1'b0;
    bus.snr_db      = '0;
    bus.recalibrate = 1'b0;
    bus.gate_ready  = 1'b1;
    rst_n           = 1'b0;
    modelReset();

    #12;
    checkOutput("reset_gate_valid", int'(bus.gate_valid), 0);
    checkOutput("reset_quiet", int'(bus.quiet_period), 1);
    checkOutput("reset_voice", int'(bus.voice_active), 0);
    checkOutput("reset_onset", int'(bus.onset), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", int'(bus.snr_ready), 1);

    // Calibration: eight silent samples.
    for (int i = 0; i < CAL; i++) applyStimulus(0, 1'b0, 1'b1, ft);
    @(negedge clk);
    checkOutput("quiet_after_cal", int'(bus.quiet_period), 0);

    // Attack run broken once, then completed.
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b0, 1'b1, ft);
    @(negedge clk);
    checkOutput("open_voice", int'(bus.voice_active), 1);
    checkOutput("open_onset", int'(bus.onset), 1);

    // Hang run broken once, then completed.
    foreach (seqB[i]) applyStimulus(seqB[i], 1'b0, 1'b1, ft);
    @(negedge clk);
    checkOutput("close_voice", int'(bus.voice_active), 0);

    // Reopen the gate, then stall the output with a sample waiting.
    for (int i = 0; i < ATK; i++) applyStimulus(20, 1'b0, 1'b1, ft);
    applyStimulus(25, 1'b0, 1'b0, ft);
    @(posedge clk);
    #1;
    bus.snr_valid  = 1'b1;
    bus.snr_db     = W'(14);
    bus.gate_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_snr_ready", int'(bus.snr_ready), 0);
      checkOutput("stall_gate_valid", int'(bus.gate_valid), 1);
      if (expQ.size() == 0) begin
        checkOutput("stall_expected_beat", 0, 1);
      end else begin
        checkOutput("stall_voice", int'(bus.voice_active), int'(expQ[0].voice));
        checkOutput("stall_onset", int'(bus.onset), int'(expQ[0].onset));
      end
    end
    applyStimulus(14, 1'b0, 1'b1, ft);
    checkOutput("accept_on_release", int'(ft), 1);
    @(negedge clk);
    checkOutput("beat_after_release", int'(bus.gate_valid), 1);

    // Recalibrate while open; the sample riding with it is dropped.
    applyStimulus(20, 1'b1, 1'b1, ft);
    @(negedge clk);
    checkOutput("quiet_after_recal", int'(bus.quiet_period), 1);
    for (int i = 0; i < 3; i++) applyStimulus(20, 1'b0, 1'b1, ft);
    // Recalibrate mid-calibration restarts the count.
    applyStimulus(0, 1'b1, 1'b1, ft);
    for (int i = 0; i < CAL; i++) applyStimulus(randomSample(), 1'b0, 1'b1, ft);

    // Randomized traffic with backpressure and occasional recalibration.
    for (int i = 0; i < 300; i++) begin
      bit rc;
      bit gr;
      rc = ($urandom_range(0, 49) == 0);
      gr = ($urandom_range(0, 3) != 0);
      applyStimulus(randomSample(), rc, gr, ft);
    end

    // Reset with a beat pending drops it at once.
    applyStimulus(20, 1'b0, 1'b0, ft);
    @(negedge clk);
    checkOutput("pending_before_reset", int'(bus.gate_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_gate_valid", int'(bus.gate_valid), 0);
    checkOutput("async_voice", int'(bus.voice_active), 0);
    checkOutput("async_quiet", int'(bus.quiet_period), 1);
    checkOutput("async_onset", int'(bus.onset), 0);
    expQ.delete();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rereset", int'(bus.snr_ready), 1);
    for (int i = 0; i < CAL + 12; i++) applyStimulus(randomSample(), 1'b0, 1'b1, ft);

    // Drain whatever is still expected.
    bus.gate_ready = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/snr_gate.md
SNR_GATE -- requirements
Module: snr_gate

Interface
REQ-001 Parameter SNR_WIDTH, 16, width of signed SNR input in dB.
REQ-002 Parameter CAL_SAMPLES, 4096, accepted samples spent in noise calibration (>=1).
REQ-003 Parameter ON_DB, 12, signed onset threshold in dB.
REQ-004 Parameter OFF_DB, 6, signed release threshold in dB (OFF_DB <= ON_DB).
REQ-005 Parameter ATTACK_COUNT, 4, consecutive samples >= ON_DB needed to open the gate (>=1).
REQ-006 Parameter HANG_COUNT, 2048, consecutive samples < OFF_DB needed to close the gate (>=1).
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 snr_db  input  SNR_WIDTH  two's-complement SNR sample from upstream SNR calculator.
REQ-010 snr_valid  input  1  snr_db valid.
REQ-011 snr_ready  output  1  block can accept snr_db.
REQ-012 recalibrate  input  1  synchronous request to restart noise calibration.
REQ-013 quiet_period  output  1  high while calibrating; drives upstream noise-floor update.
REQ-014 voice_active  output  1  gate state carried with each output beat.
REQ-015 onset  output  1  high on the output beat where voice_active rises 0->1.
REQ-016 gate_valid  output  1  output beat valid.
REQ-017 gate_ready  input  1  downstream accepts beat.

Function
REQ-018 Sample accepted iff snr_valid && snr_ready in a cycle; snr_ready = !gate_valid || gate_ready.
REQ-019 Each accepted sample produces exactly one output beat; gate_valid rises the cycle after acceptance (latency 1); beat held stable until gate_valid && gate_ready.
REQ-020 snr_db compared as signed against ON_DB/OFF_DB; no saturation; full SNR_WIDTH used.
REQ-021 States: CALIB, IDLE, ATTACK, ACTIVE, HANG; transitions occur only on accepted samples or recalibrate.
REQ-022 CALIB: quiet_period=1, voice_active=0; cal counter increments per accepted sample; on the CAL_SAMPLES-th sample -> IDLE, counter cleared.
REQ-023 IDLE: sample >= ON_DB -> ATTACK with attack count 1 (or directly ACTIVE if ATTACK_COUNT=1); else stay.
REQ-024 ATTACK: sample >= ON_DB increments count; reaching ATTACK_COUNT -> ACTIVE; sample < ON_DB -> IDLE, count cleared.
REQ-025 ACTIVE: sample < OFF_DB -> HANG with hang count 1 (or IDLE if HANG_COUNT=1); else stay.
REQ-026 HANG: sample >= OFF_DB -> ACTIVE, hang count cleared; else increment; reaching HANG_COUNT -> IDLE.
REQ-027 voice_active in a beat = 1 iff post-update state is ACTIVE or HANG; onset=1 iff that beat's voice_active=1 and previous emitted beat's was 0.
REQ-028 quiet_period is a registered state decode, high exactly while state is CALIB, independent of handshake.
REQ-029 recalibrate has priority: next state CALIB, all counters cleared, any sample accepted in the same cycle discarded (no beat produced for it); pending unconsumed beat still held until taken.
REQ-030 recalibrate while already in CALIB restarts the cal count from 0.
REQ-031 Counters sized ceil(log2(max count+1)); no wrap-around reachable.

Reset
REQ-032 While reset low: state CALIB, all counters 0, quiet_period 1, voice_active 0, onset 0, gate_valid 0; snr_ready 1 after release.
REQ-033 Reset asserted mid-beat discards the pending beat immediately (asynchronous).

Verification (CAL_SAMPLES=8, ON_DB=12, OFF_DB=6, ATTACK_COUNT=3, HANG_COUNT=4, gate_ready=1 unless stated)
REQ-034 Release reset, send 8 samples of 0 -> quiet_period high for first 8 acceptances, falls the cycle after 8th; 8 beats, all voice_active=0.
REQ-035 After calibration send 20,20,5,20,20,20 -> voice_active 0,0,0,0,0,1; onset=1 only on 6th beat.
REQ-036 From ACTIVE send 3,3,8,3,3,3,3 -> voice_active 1 on first six beats (8 resets hang), 0 on seventh.
REQ-037 Hold gate_ready=0 with pending beat, snr_valid=1 -> snr_ready=0, beat stable 5 cycles; gate_ready=1 -> beat consumed, next sample accepted same cycle.
REQ-038 Pulse recalibrate in ACTIVE with snr_valid=1 -> no beat for that sample, quiet_period=1 next cycle, next 8 beats voice_active=0.
REQ-039 Assert reset with gate_valid=1 -> gate_valid, voice_active 0 and quiet_period 1 immediately, before next clock edge.
